// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared widths, well-known register numbers and the
// write-request record used by the writeback scheduler.
package regfile_wb_scheduler_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 2 ** AW;

  localparam logic [AW-1:0] REG_ZERO = '0;
  localparam logic [AW-1:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Small synchronous skid FIFO holding long-latency results
// that lost the register file write port to the pipeline.
import regfile_wb_scheduler_pkg::*;

module regfile_wb_fifo #(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wr_req_t       din,
  input  logic          pop,
  output wr_req_t       head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  wr_req_t       mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register file write port between the WB stage and
// the mul/div result stream; tracks pending long-latency dests.
import regfile_wb_scheduler_pkg::*;

module regfile_wb_scheduler #(
  parameter int DEPTH = 2
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_reg,
  input  logic [DW-1:0]   wb_data,
  input  logic            lu_valid,
  input  logic [AW-1:0]   lu_reg,
  input  logic [DW-1:0]   lu_data,
  output logic            lu_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_reg,
  output logic            issue_ready,
  input  logic [AW-1:0]   chk_rs,
  input  logic [AW-1:0]   chk_rt,
  output logic            hazard,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  output logic [NREG-1:0] pending,
  output logic            err_waw
);

  localparam int CW = $clog2(DEPTH) + 1;

  wr_req_t       head;
  wr_req_t       din;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          push;
  logic          wb_go;
  logic          lu_acc;
  logic          head_go;
  logic          byp_go;
  logic          room;
  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (push),
    .din   (din),
    .pop   (head_go),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Ready looks only at the registered count, never at this cycle's pop.
  assign room     = (count < CW'(DEPTH));
  assign lu_ready = room && !Reset;

  assign wb_go   = !Reset && wb_valid && (wb_reg != REG_ZERO);
  assign lu_acc  = lu_valid && lu_ready && (lu_reg != REG_ZERO);
  assign head_go = !Reset && !wb_go && !empty;
  assign byp_go  = !wb_go && empty && lu_acc;
  assign push    = lu_acc && !byp_go && !full;
  assign din     = '{dst: lu_reg, data: lu_data};

  assign issue_ready = !pending[issue_reg] && !Reset;

  assign hazard = !Reset &&
    (((chk_rs != REG_ZERO) && pending[chk_rs]) ||
     ((chk_rt != REG_ZERO) && pending[chk_rt]));

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    clr      = '0;
    set      = '0;
    unique case (1'b1)
      wb_go: begin
        rf_we    = 1'b1;
        rf_waddr = wb_reg;
        rf_wdata = wb_data;
      end
      head_go: begin
        rf_we         = 1'b1;
        rf_waddr      = head.dst;
        rf_wdata      = head.data;
        clr[head.dst] = 1'b1;
      end
      byp_go: begin
        rf_we       = 1'b1;
        rf_waddr    = lu_reg;
        rf_wdata    = lu_data;
        clr[lu_reg] = 1'b1;
      end
      default: ;
    endcase
    if (issue_valid && issue_ready && (issue_reg != REG_ZERO))
      set[issue_reg] = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pending <= '0;
      err_waw <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | set;
      if (wb_go && pending[wb_reg]) err_waw <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for the writeback scheduler with a queue-based
// reference model checked every cycle plus literal spot checks.
module tb_regfile_wb_scheduler;

  localparam int DEPTH = 2;

  logic        Clock = 0;
  logic        Reset;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic        issue_ready;
  logic [4:0]  chk_rs;
  logic [4:0]  chk_rt;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;
  logic        err_waw;

  regfile_wb_scheduler #(.DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_reg(lu_reg), .lu_data(lu_data),
    .lu_ready(lu_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .issue_ready(issue_ready),
    .chk_rs(chk_rs), .chk_rt(chk_rt), .hazard(hazard),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending(pending), .err_waw(err_waw)
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of waiting results and a set of pending regs.
  logic [36:0] mq[$];
  bit          mp[32];
  bit          merr;

  typedef struct {
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          lrdy;
    bit          irdy;
    bit          hz;
    int          src;
  } exp_t;

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = mp[i];
    return v;
  endfunction

  // src: 0 none, 1 pipeline, 2 queue head, 3 direct lu result
  function automatic exp_t predict();
    exp_t e;
    bit acc;
    e = '{we: 0, wa: '0, wd: '0, lrdy: 0, irdy: 0, hz: 0, src: 0};
    if (Reset) return e;
    e.lrdy = mq.size() < DEPTH;
    e.irdy = !mp[issue_reg];
    e.hz = (chk_rs != 0 && mp[chk_rs]) || (chk_rt != 0 && mp[chk_rt]);
    acc = lu_valid && e.lrdy && lu_reg != 0;
    if (wb_valid && wb_reg != 0) begin
      e.we = 1; e.wa = wb_reg; e.wd = wb_data; e.src = 1;
    end else if (mq.size() > 0) begin
      e.we = 1; e.wa = mq[0][36:32]; e.wd = mq[0][31:0]; e.src = 2;
    end else if (acc) begin
      e.we = 1; e.wa = lu_reg; e.wd = lu_data; e.src = 3;
    end
    return e;
  endfunction

  always @(posedge Clock) begin
    exp_t e;
    if (Reset) begin
      mq.delete();
      for (int i = 0; i < 32; i++) mp[i] = 0;
      merr = 0;
    end else begin
      bit old_iss;
      e = predict();
      old_iss = mp[issue_reg];
      if (e.src == 1 && mp[wb_reg]) merr = 1;
      if (e.src == 2) begin
        mp[mq[0][36:32]] = 0;
        void'(mq.pop_front());
      end
      if (e.src == 3) mp[lu_reg] = 0;
      if (lu_valid && e.lrdy && lu_reg != 0 && e.src != 3)
        mq.push_back({lu_reg, lu_data});
      if (issue_valid && !old_iss && issue_reg != 0) mp[issue_reg] = 1;
    end
  end

  always @(negedge Clock) begin
    exp_t e;
    if (started) begin
      e = predict();
      chk("m_rf_we", rf_we, e.we);
      chk("m_rf_waddr", rf_waddr, e.wa);
      chk("m_rf_wdata", rf_wdata, e.wd);
      chk("m_lu_ready", lu_ready, e.lrdy);
      chk("m_issue_ready", issue_ready, e.irdy);
      chk("m_hazard", hazard, e.hz);
      chk("m_pending", pending, pend_vec());
      chk("m_err_waw", err_waw, merr);
    end
  end

  task automatic idle();
    wb_valid = 0; wb_reg = 0; wb_data = 0;
    lu_valid = 0; lu_reg = 0; lu_data = 0;
    issue_valid = 0; issue_reg = 0;
  endtask

  task automatic nxt();
    @(posedge Clock); #1;
  endtask

  task automatic mid();
    @(negedge Clock); #2;
  endtask

  initial begin
    Reset = 1; chk_rs = 0; chk_rt = 0;
    idle();
    repeat (3) nxt();
    Reset = 0;
    started = 1;
    mid();
    chk("rst_pending", pending, 32'h0);
    chk("rst_err", err_waw, 1'b0);
    chk("rst_we", rf_we, 1'b0);
    nxt();
    wb_valid = 1; wb_reg = 5; wb_data = 32'hDEADBEEF;
    mid();
    chk("wb_we", rf_we, 1'b1);
    chk("wb_addr", rf_waddr, 5);
    chk("wb_data", rf_wdata, 32'hDEADBEEF);
    chk("wb_pend", pending, 32'h0);
    nxt(); idle();
    issue_valid = 1; issue_reg = 8;
    mid(); chk("iss8_rdy", issue_ready, 1'b1);
    nxt(); idle();
    chk_rs = 8; lu_valid = 1; lu_reg = 8; lu_data = 32'h1234;
    mid();
    chk("byp_pend8", pending[8], 1'b1);
    chk("byp_hz", hazard, 1'b1);
    chk("byp_addr", rf_waddr, 8);
    chk("byp_data", rf_wdata, 32'h1234);
    nxt(); idle();
    mid();
    chk("byp_clr", pending[8], 1'b0);
    chk("byp_hz0", hazard, 1'b0);
    nxt(); chk_rs = 0;
    issue_valid = 1; issue_reg = 3; nxt();
    issue_reg = 4; nxt(); idle();
    wb_valid = 1; wb_reg = 10; wb_data = 32'h1;
    lu_valid = 1; lu_reg = 3; lu_data = 32'hA;
    nxt();
    lu_reg = 4; lu_data = 32'hB;
    nxt();
    lu_valid = 0;
    mid();
    chk("full_rdy", lu_ready, 1'b0);
    chk("full_wb", rf_waddr, 10);
    nxt(); wb_valid = 0;
    mid();
    chk("drain_rdy", lu_ready, 1'b0);
    chk("drain1_addr", rf_waddr, 3);
    chk("drain1_data", rf_wdata, 32'hA);
    nxt();
    mid();
    chk("drain2_addr", rf_waddr, 4);
    chk("drain2_data", rf_wdata, 32'hB);
    nxt();
    mid();
    chk("drain_done", rf_we, 1'b0);
    chk("drain_pend", pending, 32'h0);
    nxt();
    issue_valid = 1; issue_reg = 7;
    mid(); chk("iss7_rdy", issue_ready, 1'b1);
    nxt();
    mid(); chk("iss7_again", issue_ready, 1'b0);
    nxt();
    wb_valid = 1; wb_reg = 7; wb_data = 32'h77;
    mid();
    chk("waw_we_addr", rf_waddr, 7);
    chk("waw_err_pre", err_waw, 1'b0);
    nxt(); idle();
    mid();
    chk("waw_err", err_waw, 1'b1);
    chk("waw_pend7", pending[7], 1'b1);
    nxt();
    lu_valid = 1; lu_reg = 7; lu_data = 32'h70;
    issue_valid = 1; issue_reg = 7;
    mid();
    chk("res7_addr", rf_waddr, 7);
    chk("res7_irdy", issue_ready, 1'b0);
    nxt(); idle(); issue_reg = 7;
    mid(); chk("res7_irdy1", issue_ready, 1'b1);
    nxt();
    issue_valid = 1; issue_reg = 9; nxt(); idle();
    wb_valid = 1; wb_reg = 0; wb_data = 32'hFFFF;
    lu_valid = 1; lu_reg = 9; lu_data = 32'h99;
    mid();
    chk("r0_addr", rf_waddr, 9);
    chk("r0_data", rf_wdata, 32'h99);
    nxt(); idle();
    mid(); chk("r0_pend", pending, 32'h0);
    nxt();
    issue_valid = 1; issue_reg = 3; nxt();
    issue_reg = 11; nxt();
    issue_reg = 12; nxt(); idle();
    wb_valid = 1; wb_reg = 1; wb_data = 32'h5;
    lu_valid = 1; lu_reg = 11; lu_data = 32'hB1;
    nxt();
    lu_reg = 12; lu_data = 32'hC1;
    nxt(); idle();
    Reset = 1; chk_rs = 3;
    mid();
    chk("rr_we", rf_we, 1'b0);
    chk("rr_lrdy", lu_ready, 1'b0);
    chk("rr_irdy", issue_ready, 1'b0);
    chk("rr_hz", hazard, 1'b0);
    chk("rr_pend_held", pending, 32'h1808);
    nxt();
    Reset = 0;
    mid();
    chk("rr_pend", pending, 32'h0);
    chk("rr_err", err_waw, 1'b0);
    chk("rr_we2", rf_we, 1'b0);
    chk("rr_lrdy2", lu_ready, 1'b1);
    repeat (3) nxt();
    mid();
    chk("rr_idle", rf_we, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Owns the single write port of the 32x32 register file and shares it between two sources:
  - the pipeline writeback stage, which has fixed top priority and is never stalled;
  - the long-latency unit (mul/div) result stream, which uses a valid/ready handshake and a small skid FIFO.
- Holds a per-register pending scoreboard for issued long-latency ops and drives the decode-stage hazard stall.
- Sits between the WB stage, the mul/div unit and the register file write inputs.

Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of 2, at least 2)
- AW, 5, register address width
- DW, 32, data width
- NREG, 32, number of architectural registers (2**AW)

Ports:
- Clock  in  1  system clock; all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- wb_valid  in  1  pipeline writeback request this cycle
- wb_reg  in  AW  pipeline destination register
- wb_data  in  DW  pipeline write data
- lu_valid  in  1  long-latency result valid
- lu_reg  in  AW  long-latency destination register
- lu_data  in  DW  long-latency result data
- lu_ready  out  1  result accepted when lu_valid && lu_ready
- issue_valid  in  1  decode issues a long-latency op
- issue_reg  in  AW  destination of the issued op
- issue_ready  out  1  issue accepted when issue_valid && issue_ready
- chk_rs  in  AW  decode source register 1
- chk_rt  in  AW  decode source register 2
- hazard  out  1  a decode source register is pending
- rf_we  out  1  register file write enable
- rf_waddr  out  AW  register file write address
- rf_wdata  out  DW  register file write data
- pending  out  NREG  scoreboard bit vector
- err_waw  out  1  sticky: pipeline wrote a pending register

Behaviour:
- Interface: one clock, Clock. Reset is synchronous and active-high.
- Reset (sampled at posedge): FIFO emptied, pending = 0, err_waw = 0.
  - While Reset is high: rf_we = 0, lu_ready = 0, issue_ready = 0, hazard = 0.
  - Reset mid-operation discards all buffered results and pending bits.
- Register 0:
  - Any request with reg == 0 is dropped and does not occupy the port.
  - An issue to reg 0 is accepted but sets no pending bit.
- Write port (combinational, same cycle; the register file captures on the following negedge):
  - Priority 1: valid pipeline write (wb_valid && wb_reg != 0) drives rf_we = 1, rf_waddr = wb_reg, rf_wdata = wb_data.
  - Else, FIFO not empty: the FIFO head is written and dequeued at posedge.
  - Else, bypass: lu_valid && lu_ready && lu_reg != 0 writes lu_data directly, with no enqueue.
  - Otherwise rf_we = 0; rf_waddr and rf_wdata hold 0.
- Accepted lu results are enqueued at posedge when they are not bypassed. FIFO order is strictly preserved and the bypass is allowed only when the FIFO is empty.
- lu_ready = (FIFO count < DEPTH) && !Reset.
  - Registered count only; no combinational dependence on the dequeue.
  - A full FIFO drops ready even in a cycle where the head drains.
- Scoreboard:
  - Set: pending[issue_reg] is set at posedge on an accepted issue.
  - Clear: pending[r] is cleared at posedge in the cycle the lu result for r is written to the port (FIFO head or bypass).
  - Clearing uses the state before the update.
- issue_ready = !pending[issue_reg] && !Reset. This enforces at most one outstanding op per register, so set and clear of the same register never coincide.
- hazard = (chk_rs != 0 && pending[chk_rs]) || (chk_rt != 0 && pending[chk_rt]). It is combinational and uses the pending state before the current cycle's clear; there is no same-cycle forwarding.
- err_waw: set at posedge when a valid pipeline write targets a register with its pending bit set. The pipeline write still happens and pending is unchanged. err_waw is cleared only by Reset.
- Latency:
  - Pipeline write: 0 cycles to the port.
  - lu result with idle port and empty FIFO: 0 cycles.
  - Otherwise the lu result waits one cycle per preceding FIFO entry plus one cycle per pipeline-write cycle.

Decomposition:
- Shared package holds:
  - AW, DW, NREG;
  - REG_ZERO = 0 and REG_RA = 31;
  - the write-request record type (reg, data).
- One sub-module is natural: regfile_wb_fifo, a DEPTH-entry synchronous FIFO with push, pop, head, count, empty and full. Its reset behaviour matches this block.
- Arbitration, bypass and scoreboard logic stay in the top level.

Test Plan:
- Reset, then wb_valid = 1, wb_reg = 5, wb_data = 0xDEADBEEF -> same cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF; pending = 0.
- Issue reg 8, then lu result (8, 0x1234) on an idle port -> bypassed the same cycle: rf_we = 1, rf_waddr = 8; pending[8] goes 1 then 0; hazard = 1 for chk_rs = 8 until the clear.
- Issue regs 3 and 4, present lu results (3, 0xA) and (4, 0xB) back-to-back while wb_valid = 1 for 3 cycles:
  - FIFO fills and lu_ready = 0;
  - after wb drops, writes occur in order: 3 then 4 on consecutive cycles.
- Issue reg 7 and then attempt a second issue to 7 -> issue_ready = 0 until the result for 7 is written; a wb write to 7 in between sets err_waw = 1.
- wb_reg = 0 with wb_valid = 1 together with a pending lu result for reg 9 -> the wb write is dropped and reg 9 is written the same cycle.
- Reset asserted with 2 FIFO entries and pending[3] = 1 -> next cycle the FIFO is empty, pending = 0, err_waw = 0, rf_we = 0, and nothing is written.
